pipe_hazard_ctrl: RTL and testbench

//  Stall/flush sequencer for the 5-stage pipeline; companion to the EX/MEM forwarding unit.

---
 rtl/pipe_hazard_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl -- stall/flush sequencer for the 5-stage pipeline.
//
// Sits next to the EX/MEM forwarding unit. It does four things:
//   - inserts one bubble for a load-use hazard that forwarding cannot cover
//   - freezes the pipe while data memory is busy
//   - flushes IF/ID and ID/EX on a taken branch
//   - stops the machine for good once HLT retires
//
// Ports
//   clk, rst_n          rising-edge clock, async active-low reset
//   IF_ID_RegisterRs/Rt source registers of the instruction in ID
//   IF_ID_UsesRt        ID instruction reads Rt
//   IF_ID_IsStore       ID instruction is a store (Rt is store data)
//   ID_EX_MemRead       EX instruction is a load
//   ID_EX_RegisterRd    destination register of the EX instruction
//   branch_taken        branch/jump in EX resolved taken
//   imem_stall          instruction memory not ready
//   dmem_stall          data memory busy
//   halt_wb             HLT is in WB
//   pc_en, if_id_en, ex_mem_en            stage write enables
//   if_id_flush, id_ex_flush, mem_wb_flush  load a NOP into that register
//   halted              sticky, set the cycle after HLT retires
//   mem_timeout         sticky, dmem wait reached MEM_TIMEOUT cycles
//
// Build option: define STALL_PERF_EN to add the saturating counters
//   perf_lu_cnt, perf_mem_cnt and perf_flush_cnt.
module pipe_hazard_ctrl #(
  parameter int REG_W       = 5,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 8,
  parameter int PERF_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] IF_ID_RegisterRs,
  input  logic [REG_W-1:0] IF_ID_RegisterRt,
  input  logic             IF_ID_UsesRt,
  input  logic             IF_ID_IsStore,
  input  logic             ID_EX_MemRead,
  input  logic [REG_W-1:0] ID_EX_RegisterRd,
  input  logic             branch_taken,
  input  logic             imem_stall,
  input  logic             dmem_stall,
  input  logic             halt_wb,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_en,
  output logic             mem_wb_flush,
  output logic             halted,
  output logic             mem_timeout
`ifdef STALL_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_lu_cnt,
  output logic [PERF_W-1:0] perf_mem_cnt,
  output logic [PERF_W-1:0] perf_flush_cnt
`endif
);

  if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > (2**CNT_W) - 1 || PERF_W < 1) begin : g_bad_cfg
    $error("pipe_hazard_ctrl: MEM_TIMEOUT must be 1..2^CNT_W-1 and PERF_W >= 1");
  end

  typedef enum logic [1:0] {RUN, MEM_WAIT, HALTED} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(MEM_TIMEOUT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q;

  logic lu;    // load-use hazard visible in ID this cycle
  logic frz;   // whole pipe frozen on a data-memory wait
  logic flow;  // normal flow: branch / load-use / imem rules decide

  // A store whose only match is its data operand (Rt) is fine: the loaded
  // value is forwarded MEM-to-MEM, so only Rs or a non-store Rt stalls.
  assign lu = ID_EX_MemRead && (ID_EX_RegisterRd != '0) &&
              ((ID_EX_RegisterRd == IF_ID_RegisterRs) ||
               (IF_ID_UsesRt && !IF_ID_IsStore && (ID_EX_RegisterRd == IF_ID_RegisterRt)));

  // HLT retirement outranks a dmem wait in RUN; once in MEM_WAIT only the
  // memory release matters.
  assign frz  = ((state_q == RUN) && !halt_wb && dmem_stall) ||
                ((state_q == MEM_WAIT) && dmem_stall);
  assign flow = ((state_q == RUN) && !halt_wb && !dmem_stall) ||
                ((state_q == MEM_WAIT) && !dmem_stall);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_en    = 1'b1;
    mem_wb_flush = 1'b0;

    case (state_q)
      RUN: begin
        if (halt_wb) begin
          state_d = HALTED;
        end else if (dmem_stall) begin
          state_d = MEM_WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (dmem_stall) begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        end else begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase

    if (frz) begin
      // Bubble into MEM/WB so the instruction already in WB is not repeated.
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (flow) begin
      if (branch_taken) begin
        // Squashes a load-use victim in ID too, so no bubble follows.
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (lu) begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
      end else if (imem_stall) begin
        pc_en       = 1'b0;
        if_id_flush = 1'b1;
      end
    end else begin
      // HLT retiring this cycle, or already halted: hold everything and
      // leave MEM/WB alone so HLT itself completes.
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      ex_mem_en = 1'b0;
    end

    if (!rst_n) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      ex_mem_en    = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      mem_wb_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      // Comparing the next count makes the flag visible after exactly
      // MEM_TIMEOUT consecutive busy cycles.
      timeout_q <= timeout_q | (cnt_d == TO_VAL);
    end
  end

  assign halted      = (state_q == HALTED);
  assign mem_timeout = timeout_q;

`ifdef STALL_PERF_EN
  logic [PERF_W-1:0] perf_lu_q, perf_mem_q, perf_flush_q;

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v, input logic hit);
    return (hit && (v != {PERF_W{1'b1}})) ? v + PERF_W'(1) : v;
  endfunction

  // Nothing counts in HALTED because neither frz nor flow is ever set there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_lu_q    <= '0;
      perf_mem_q   <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_lu_q    <= sat_inc(perf_lu_q, flow && !branch_taken && lu);
      perf_mem_q   <= sat_inc(perf_mem_q, frz);
      perf_flush_q <= sat_inc(perf_flush_q, flow && branch_taken);
    end
  end

  assign perf_lu_cnt    = perf_lu_q;
  assign perf_mem_cnt   = perf_mem_q;
  assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (MEM_TIMEOUT 255 and 3) share
// one stimulus stream. A rule-level model predicts every output each cycle;
// directed vectors carry hand-computed values for the key scenarios.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] rs = '0, rt = '0, rd = '0;
  logic       uses_rt = 1'b0, is_store = 1'b0, memread = 1'b0;
  logic       br = 1'b0, imem = 1'b0, dmem = 1'b0, halt = 1'b0;

  logic pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_en, mem_wb_flush, halted, mem_timeout;
  logic pc_en3, if_id_en3, if_id_flush3, id_ex_flush3, ex_mem_en3, mem_wb_flush3, halted3, mem_timeout3;

`ifdef STALL_PERF_EN
  logic [15:0] p_lu, p_mem, p_fl, p_lu3, p_mem3, p_fl3;
`endif

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .IF_ID_RegisterRs(rs), .IF_ID_RegisterRt(rt), .IF_ID_UsesRt(uses_rt), .IF_ID_IsStore(is_store),
    .ID_EX_MemRead(memread), .ID_EX_RegisterRd(rd), .branch_taken(br), .imem_stall(imem),
    .dmem_stall(dmem), .halt_wb(halt),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_en(ex_mem_en), .mem_wb_flush(mem_wb_flush), .halted(halted), .mem_timeout(mem_timeout)
`ifdef STALL_PERF_EN
    , .perf_lu_cnt(p_lu), .perf_mem_cnt(p_mem), .perf_flush_cnt(p_fl)
`endif
  );

  pipe_hazard_ctrl #(.MEM_TIMEOUT(3)) dut_t3 (
    .clk(clk), .rst_n(rst_n),
    .IF_ID_RegisterRs(rs), .IF_ID_RegisterRt(rt), .IF_ID_UsesRt(uses_rt), .IF_ID_IsStore(is_store),
    .ID_EX_MemRead(memread), .ID_EX_RegisterRd(rd), .branch_taken(br), .imem_stall(imem),
    .dmem_stall(dmem), .halt_wb(halt),
    .pc_en(pc_en3), .if_id_en(if_id_en3), .if_id_flush(if_id_flush3), .id_ex_flush(id_ex_flush3),
    .ex_mem_en(ex_mem_en3), .mem_wb_flush(mem_wb_flush3), .halted(halted3), .mem_timeout(mem_timeout3)
`ifdef STALL_PERF_EN
    , .perf_lu_cnt(p_lu3), .perf_mem_cnt(p_mem3), .perf_flush_cnt(p_fl3)
`endif
  );

  // {pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_en, mem_wb_flush}
  wire [5:0] ctl  = {pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_en, mem_wb_flush};
  wire [5:0] ctl3 = {pc_en3, if_id_en3, if_id_flush3, id_ex_flush3, ex_mem_en3, mem_wb_flush3};

  int checks = 0;
  int errs = 0;

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  // halt: machine stopped; wt: inside a data-memory wait; run: consecutive
  // busy cycles in the current wait; to*: sticky timeout per instance.
  typedef struct packed {
    logic        halt;
    logic        wt;
    logic [31:0] run;
    logic        to255;
    logic        to3;
  } mstate_t;

  mstate_t m = '0;

  function automatic mstate_t step(input mstate_t s);
    mstate_t n = s;
    if (s.halt) return n;
    if (!s.wt) begin
      if (halt) n.halt = 1'b1;
      else if (dmem) begin
        n.wt  = 1'b1;
        n.run = 1;
      end
    end else if (dmem) begin
      n.run = s.run + 1;
    end else begin
      n.wt  = 1'b0;
      n.run = 0;
    end
    if (n.run == 3)   n.to3   = 1'b1;
    if (n.run == 255) n.to255 = 1'b1;
    return n;
  endfunction

  function automatic logic [5:0] exp_ctl();
    logic hz;
    hz = memread && (rd != 0) && ((rd == rs) || (uses_rt && !is_store && (rd == rt)));
    if (!rst_n)            return 6'b001101;
    if (m.halt)            return 6'b000000;
    if (!m.wt && halt)     return 6'b000000;
    if (dmem)              return 6'b000001;
    if (br)                return 6'b111110;
    if (hz)                return 6'b000110;
    if (imem)              return 6'b011010;
    return 6'b110010;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else        m <= step(m);
  end

  always @(negedge clk) begin
    chk("ctl", {2'b00, ctl}, {2'b00, exp_ctl()});
    chk("ctl_t3", {2'b00, ctl3}, {2'b00, exp_ctl()});
    chk("halted", {7'd0, halted}, {7'd0, m.halt});
    chk("halted_t3", {7'd0, halted3}, {7'd0, m.halt});
    chk("timeout", {7'd0, mem_timeout}, {7'd0, m.to255});
    chk("timeout_t3", {7'd0, mem_timeout3}, {7'd0, m.to3});
  end

  // ---------------- stimulus ----------------
  task automatic setv(input logic [4:0] a_rs, a_rt, input logic a_ur, a_st, a_mr,
                      input logic [4:0] a_rd, input logic a_br, a_im, a_dm, a_ht);
    rs = a_rs; rt = a_rt; uses_rt = a_ur; is_store = a_st; memread = a_mr;
    rd = a_rd; br = a_br; imem = a_im; dmem = a_dm; halt = a_ht;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    chk("rst_ctl", {2'b00, ctl}, 8'b00001101);
    chk("rst_halted", {7'd0, halted}, 8'd0);
    chk("rst_timeout", {7'd0, mem_timeout}, 8'd0);
    #20 rst_n = 1'b1;
    tick();

    setv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); #2 chk("idle", {2'b00, ctl}, 8'b00110010); tick();
    // lw r3 ; add r4,r3,r1
    setv(3, 1, 1, 0, 1, 3, 0, 0, 0, 0); #2 chk("lu_bubble", {2'b00, ctl}, 8'b00000110); tick();
    setv(3, 1, 1, 0, 0, 0, 0, 0, 0, 0); #2 chk("lu_after", {2'b00, ctl}, 8'b00110010); tick();
    setv(1, 3, 1, 0, 1, 3, 0, 0, 0, 0); #2 chk("lu_rt", {2'b00, ctl}, 8'b00000110); tick();
    // lw r3 ; sw r3,0(r5)
    setv(5, 3, 1, 1, 1, 3, 0, 0, 0, 0); #2 chk("sw_nostall", {2'b00, ctl}, 8'b00110010); tick();
    setv(5, 3, 0, 0, 1, 3, 0, 0, 0, 0); #2 chk("rt_unused", {2'b00, ctl}, 8'b00110010); tick();
    setv(0, 0, 1, 0, 1, 0, 0, 0, 0, 0); #2 chk("r0_nostall", {2'b00, ctl}, 8'b00110010); tick();
    setv(3, 3, 1, 0, 1, 3, 1, 0, 0, 0); #2 chk("br_lu", {2'b00, ctl}, 8'b00111110); tick();
    setv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); #2 chk("br_no_bubble", {2'b00, ctl}, 8'b00110010); tick();
    setv(0, 0, 0, 0, 0, 0, 0, 1, 0, 0); #2 chk("imem", {2'b00, ctl}, 8'b00011010); tick();

    // five busy cycles: the MEM_TIMEOUT=3 copy flags from the 4th on
    setv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int k = 1; k <= 5; k++) begin
      #2;
      chk("dmem_frz", {2'b00, ctl}, 8'b00000001);
      chk("dmem_to255", {7'd0, mem_timeout}, 8'd0);
      chk("dmem_to3", {7'd0, mem_timeout3}, (k >= 4) ? 8'd1 : 8'd0);
      tick();
    end
    setv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); #2;
    chk("dmem_rel", {2'b00, ctl}, 8'b00110010);
    chk("rel_to3", {7'd0, mem_timeout3}, 8'd1);
    chk("rel_to255", {7'd0, mem_timeout}, 8'd0);
    tick();

    // branch held in EX during a wait flushes on release
    setv(0, 0, 0, 0, 0, 0, 1, 0, 1, 0); #2 chk("br_wait", {2'b00, ctl}, 8'b00000001); tick();
    #2 chk("br_wait2", {2'b00, ctl}, 8'b00000001); tick();
    setv(0, 0, 0, 0, 0, 0, 1, 0, 0, 0); #2 chk("br_release", {2'b00, ctl}, 8'b00111110); tick();
    // load-use pair held during a wait bubbles on release
    setv(2, 0, 0, 0, 1, 2, 0, 0, 1, 0); #2 chk("lu_wait", {2'b00, ctl}, 8'b00000001); tick();
    setv(2, 0, 0, 0, 1, 2, 0, 0, 0, 0); #2 chk("lu_release", {2'b00, ctl}, 8'b00000110); tick();

    // reset in the middle of a wait
    setv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_wait_ctl", {2'b00, ctl}, 8'b00001101);
    chk("rst_wait_to3", {7'd0, mem_timeout3}, 8'd0);
    #3 rst_n = 1'b1;
    tick();
    setv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); #2 chk("after_rst_run", {2'b00, ctl}, 8'b00110010); tick();

    // HLT retires, machine stops, reset recovers
    setv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); #2;
    chk("halt_cycle", {2'b00, ctl}, 8'b00000000);
    chk("halt_cycle_h", {7'd0, halted}, 8'd0);
    tick();
    setv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); #2;
    chk("halted_set", {7'd0, halted}, 8'd1);
    chk("halted_ctl", {2'b00, ctl}, 8'b00000000);
    tick();
    setv(0, 0, 0, 0, 0, 0, 1, 1, 1, 0); #2;
    chk("halted_sticky", {7'd0, halted}, 8'd1);
    chk("halted_ignores", {2'b00, ctl}, 8'b00000000);
    rst_n = 1'b0;
    #1;
    chk("halt_rst_h", {7'd0, halted}, 8'd0);
    chk("halt_rst_ctl", {2'b00, ctl}, 8'b00001101);
    #3 rst_n = 1'b1;
    tick();
    setv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); #2;
    chk("halt_recover", {2'b00, ctl}, 8'b00110010);
    chk("halt_recover_h", {7'd0, halted}, 8'd0);
    tick();

    // mixed traffic, checked by the per-cycle model comparison
    for (int i = 0; i < 400; i++) begin
      logic d;
      if (i % 60 == 59) begin
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
      d = dmem ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      setv(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0), d,
           1'($urandom_range(0, 39) == 0));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
